imm_extend_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational immediate extender.
- Extracts and extends the immediate for all RV formats at XLEN 32 or 64, including U-type and CSR zimm.
- Carries a sideband tag and flags illegal ImmSrc codes.
- Sits between decode and execute as one registered stage with valid/ready handshakes and a 2-entry skid buffer, so backpressure never drops or reorders instructions.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/imm_decode.sv | 35 +++
 rtl/imm_extend_pipe.sv | 142 ++++++++++++++
 tb/tb_imm_extend_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the immediate-extension pipe: format select codes,
// occupancy states of the output/skid pair, and the ImmSrc field width.
package cpu_pkg;

  localparam int IMMSRC_W = 3;

  typedef enum logic [IMMSRC_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4,
    IMM_Z = 3'd5
  } imm_src_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } imm_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: picks the immediate field for the
// selected RV format out of instruction bits [31:7] and extends it to XLEN.
// Codes 6 and 7 are not formats; they yield zero and raise err_o.
module imm_decode
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]         instr_i,
  input  logic [IMMSRC_W-1:0] immsrc_i,
  output logic [XLEN-1:0]     imm_o,
  output logic                err_o
);

  // Re-index so field slices read like the ISA manual.
  logic [31:7] ins;
  assign ins = instr_i;

  // Every signed format carries instr[31] in its top bit, so a signed size
  // cast of the assembled field performs the sign extension to XLEN.
  always_comb begin
    imm_o = '0;
    err_o = 1'b0;
    case (imm_src_e'(immsrc_i))
      IMM_I:   imm_o = XLEN'($signed(ins[31:20]));
      IMM_S:   imm_o = XLEN'($signed({ins[31:25], ins[11:7]}));
      IMM_B:   imm_o = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      IMM_J:   imm_o = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      IMM_U:   imm_o = XLEN'($signed({ins[31:12], 12'b0}));
      IMM_Z:   imm_o = XLEN'(ins[19:15]);
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// One registered decode->execute stage for immediates. The input side
// extends the immediate combinationally; results land in an output register
// backed by a single skid entry, so in_ready can be a flop (no path from
// out_ready) without ever dropping or reordering an instruction.
//
//   state | meaning
//   EMPTY | nothing held, out_valid low
//   ONE   | output register holds the oldest entry
//   FULL  | output register plus skid hold entries, in_ready low
module imm_extend_pipe
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [24:0]         in_instr,
  input  logic [IMMSRC_W-1:0] in_immsrc,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_imm,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end

  imm_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;

  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;

  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_err_q, skid_err_d;

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;
  logic            acc;
  logic            pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i  (in_instr),
    .immsrc_i (in_immsrc),
    .imm_o    (dec_imm),
    .err_o    (dec_err)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_imm   = out_imm_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

  assign acc = in_valid & in_ready_q;
  assign pop = out_valid & out_ready;

  // Occupancy transitions and data steering; flush overrides everything and
  // leaves the data registers untouched since only out_valid matters then.
  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_tag_d  = out_tag_q;
    out_err_d  = out_err_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_err_d = skid_err_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d   = ONE;
            out_imm_d = dec_imm;
            out_tag_d = in_tag;
            out_err_d = dec_err;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            state_d    = FULL;
            skid_imm_d = dec_imm;
            skid_tag_d = in_tag;
            skid_err_d = dec_err;
          end else if (acc && pop) begin
            out_imm_d = dec_imm;
            out_tag_d = in_tag;
            out_err_d = dec_err;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d   = ONE;
            out_imm_d = skid_imm_q;
            out_tag_d = skid_tag_q;
            out_err_d = skid_err_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    in_ready_d = (state_d != FULL);
  end

  // State, handshake flop and held entries; reset empties both slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      out_err_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_imm_q  <= out_imm_d;
      out_tag_q  <= out_tag_d;
      out_err_q  <= out_err_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_err_q <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: an XLEN=64 and an XLEN=32 instance see the same
// stimulus; a queue of expected entries tracks occupancy and output order.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [24:0] in_instr;
  logic [2:0]  in_immsrc;
  logic [7:0]  in_tag;

  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;
  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [7:0]  out_tag32;

  imm_extend_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
  );

  imm_extend_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
  );

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference extender built from shifts and masks on the sign-extended word.
  function automatic logic [63:0] model_imm(input logic [31:0] w, input logic [2:0] src);
    logic signed [31:0] ws;
    logic signed [63:0] iw;
    logic signed [63:0] t;
    logic [63:0]        r;
    ws = w;
    iw = ws;
    r  = '0;
    case (src)
      3'd0: begin t = iw >>> 20; r = t; end
      3'd1: begin t = iw >>> 20; r = (t & ~64'h1F) | ((iw >> 7) & 64'h1F); end
      3'd2: begin
        t = iw >>> 19;
        r = (t & ~64'hFFF) | ((iw >> 20) & 64'h7E0) | ((iw >> 7) & 64'h1E) | ((iw << 4) & 64'h800);
      end
      3'd3: begin
        t = iw >>> 11;
        r = (t & ~64'hFFFFF) | (iw & 64'hFF000) | ((iw >> 9) & 64'h800) | ((iw >> 20) & 64'h7FE);
      end
      3'd4: r = iw & ~64'hFFF;
      3'd5: r = (iw >> 15) & 64'h1F;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Called at a falling edge with inputs settled: checks occupancy and the
  // head entry, updates the queue for the coming rising edge, then advances.
  task automatic tick();
    exp_t e;
    logic [31:0] w;
    check_eq("valid64", {63'b0, out_valid64}, {63'b0, sb.size() != 0});
    check_eq("valid32", {63'b0, out_valid32}, {63'b0, sb.size() != 0});
    check_eq("ready64", {63'b0, in_ready64}, {63'b0, sb.size() < 2});
    check_eq("ready32", {63'b0, in_ready32}, {63'b0, sb.size() < 2});
    if (flush) begin
      sb.delete();
    end else begin
      if (out_valid64 && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("imm64", out_imm64, e.imm);
        check_eq("imm32", {32'b0, out_imm32}, {32'b0, e.imm[31:0]});
        check_eq("tag64", {56'b0, out_tag64}, {56'b0, e.tag});
        check_eq("tag32", {56'b0, out_tag32}, {56'b0, e.tag});
        check_eq("err64", {63'b0, out_err64}, {63'b0, e.err});
        check_eq("err32", {63'b0, out_err32}, {63'b0, e.err});
      end
      if (in_valid && in_ready64) begin
        w     = {in_instr, 7'b0};
        e.imm = model_imm(w, in_immsrc);
        e.tag = in_tag;
        e.err = (in_immsrc >= 3'd6);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] w, input logic [2:0] src, input logic [7:0] tag);
    in_valid  = 1'b1;
    in_instr  = w[31:7];
    in_immsrc = src;
    in_tag    = tag;
  endtask

  task automatic send(input logic [31:0] w, input logic [2:0] src, input logic [7:0] tag);
    logic acc;
    acc = 1'b0;
    drive(w, src, tag);
    for (int i = 0; i < 20; i++) begin
      acc = in_ready64;
      tick();
      if (acc) break;
    end
    if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    check_eq("drain_left", 64'(sb.size()), 64'd0);
  endtask

  logic [31:0] rw;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_immsrc = '0;
    in_tag    = '0;
    #12;
    check_eq("rst_valid", {63'b0, out_valid64}, 64'd0);
    check_eq("rst_imm64", out_imm64, 64'd0);
    check_eq("rst_imm32", {32'b0, out_imm32}, 64'd0);
    check_eq("rst_tag", {56'b0, out_tag64}, 64'd0);
    check_eq("rst_err", {63'b0, out_err64}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed formats, no backpressure.
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 8'h11);
    send(32'hFE112E23, 3'd1, 8'h12);
    send(32'hFFDFF06F, 3'd3, 8'h13);
    send(32'h000F8073, 3'd5, 8'h14);
    send(32'h800002B7, 3'd4, 8'h15);
    send(32'hFE000EE3, 3'd2, 8'h16);
    send(32'h7FF00093, 3'd0, 8'h17);
    send(32'h12345678, 3'd7, 8'hA5);
    send(32'hFFFFFFFF, 3'd6, 8'h5A);
    drain();

    // Backpressure: third tag must wait upstream until out_ready returns.
    out_ready = 1'b0;
    send(32'h00100093, 3'd0, 8'd1);
    send(32'h00200093, 3'd0, 8'd2);
    drive(32'h00300093, 3'd0, 8'd3);
    repeat (3) tick();
    out_ready = 1'b1;
    send(32'h00300093, 3'd0, 8'd3);
    drain();

    // Flush in ONE with a same-cycle accept: that input must vanish.
    out_ready = 1'b0;
    send(32'h00400093, 3'd0, 8'h40);
    drive(32'h00500093, 3'd0, 8'h41);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();

    // Flush in FULL with in_valid high.
    send(32'h00600093, 3'd0, 8'h60);
    send(32'h00700093, 3'd0, 8'h61);
    drive(32'h00800093, 3'd0, 8'h62);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    send(32'h00900093, 3'd1, 8'h63);
    drain();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      rw        = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rw[31:7];
      in_immsrc = 3'($urandom_range(0, 7));
      in_tag    = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    send(32'hFFF00093, 3'd0, 8'hC1);
    send(32'hFE112E23, 3'd1, 8'hC2);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {63'b0, out_valid64}, 64'd0);
    check_eq("midrst_imm64", out_imm64, 64'd0);
    check_eq("midrst_imm32", {32'b0, out_imm32}, 64'd0);
    check_eq("midrst_tag", {56'b0, out_tag64}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    send(32'h800002B7, 3'd4, 8'hD0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
